// File: rtl/alu_pkg.sv
// Shared ALU-stage definitions: nibble width, saturation limits and the
// state type of the serial subtractor.
package alu_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam logic [15:0] SAT_POS  = 16'h7FFF;
  localparam logic [15:0] SAT_NEG  = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsub_state_t;

endpackage

// File: rtl/nibble_sub4.sv
// 4-bit A + ~B + cin slice with generate/propagate carry lookahead.
module nibble_sub4
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_cout
);

  logic [NIBBLE_W-1:0] w_g;
  logic [NIBBLE_W-1:0] w_p;
  logic [NIBBLE_W:0]   w_c;

  assign w_g = i_a & ~i_b;
  assign w_p = i_a ^ ~i_b;

  // Flattened lookahead terms so no carry ripples through the slice.
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[NIBBLE_W-1:0];
  assign o_cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_sub.sv
// Nibble-serial two's-complement subtractor (A - B) with valid/ready on both
// sides and N/Z/V/borrow flags. Optional saturation: NSUB_SATURATE_EN.
module nibble_serial_sub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v,
  output logic             borrow_out
);

  localparam int unsigned NSTEPS = WIDTH / NIBBLE_W;
  localparam int unsigned STEP_W = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH == 0) begin : g_width_check
    $error("nibble_serial_sub: WIDTH must be a non-zero multiple of 4");
  end

  nsub_state_t         r_state;
  nsub_state_t         w_state_nxt;
  logic [STEP_W-1:0]   r_step;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic                r_carry;
  logic [WIDTH-1:0]    r_diff;
  logic                r_flag_n;
  logic                r_flag_z;
  logic                r_flag_v;
  logic                r_borrow;
  logic                r_in_ready;
  logic                r_out_valid;

  logic                w_accept;
  logic                w_last;
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;
  logic [WIDTH-1:0]    w_raw;
  logic [WIDTH-1:0]    w_final;
  logic                w_v;

  assign w_accept = in_valid & r_in_ready;
  assign w_last   = (r_state == RUN) && (r_step == LAST_STEP);
  assign w_a_nib  = r_a[NIBBLE_W*int'(r_step) +: NIBBLE_W];
  assign w_b_nib  = r_b[NIBBLE_W*int'(r_step) +: NIBBLE_W];

  nibble_sub4 u_nibble_sub4 (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Full result as it will look once the top nibble lands, for flag/saturation.
  always_comb begin
    w_raw = r_diff;
    w_raw[WIDTH-1 -: NIBBLE_W] = w_sum;
    w_v = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_raw[WIDTH-1] ^ r_a[WIDTH-1]);
`ifdef NSUB_SATURATE_EN
    if (w_v) begin
      w_final = {r_a[WIDTH-1], {(WIDTH-1){~r_a[WIDTH-1]}}};
    end else begin
      w_final = w_raw;
    end
`else
    w_final = w_raw;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = RUN;
      RUN:     if (r_step == LAST_STEP) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b1;
      r_diff   <= '0;
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_v <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= 1'b1;
        r_step  <= '0;
      end else if (r_state == RUN) begin
        r_carry <= w_cout;
        if (w_last) begin
          r_step   <= '0;
          r_diff   <= w_final;
          r_flag_n <= w_final[WIDTH-1];
          r_flag_z <= (w_final == '0);
          r_flag_v <= w_v;
          r_borrow <= ~w_cout;
        end else begin
          r_step <= r_step + STEP_W'(1);
          r_diff[NIBBLE_W*int'(r_step) +: NIBBLE_W] <= w_sum;
        end
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign diff       = r_diff;
  assign flag_n     = r_flag_n;
  assign flag_z     = r_flag_z;
  assign flag_v     = r_flag_v;
  assign borrow_out = r_borrow;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub: directed vector table, DONE-hold,
// mid-run reset and randomized ops against an arithmetic reference model.
module tb_nibble_serial_sub;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         flag_n, flag_z, flag_v, borrow_out;

  int errors = 0;
  int checks = 0;

  nibble_serial_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         n;
    logic         z;
    logic         v;
    logic         bo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer subtraction, range test for overflow.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] d, output logic n, output logic z,
                       output logic v, output logic bo);
    int sa, sb, sd;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    sd = sa - sb;
    bo = (int'(ma) < int'(mb));
    v  = (sd > 32767) || (sd < -32768);
    d  = W'(int'(ma) - int'(mb));
`ifdef NSUB_SATURATE_EN
    if (v) d = (sd > 0) ? 16'h7FFF : 16'h8000;
`endif
    n = d[W-1];
    z = (d == '0);
  endtask

  logic [W-1:0] r_d;
  logic         r_n, r_z, r_v, r_bo;
  int           r_lat;

  // Issue one op; noise toggles in_valid/a/b while the unit is busy.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input bit noise);
    int wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    while (!in_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    in_valid = 1'b1;
    a = oa;
    b = ob;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    r_lat = 0;
    while (!out_valid && r_lat < 20) begin
      if (noise) begin
        in_valid = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      r_lat++;
    end
    in_valid = 1'b0;
    r_d  = diff;
    r_n  = flag_n;
    r_z  = flag_z;
    r_v  = flag_v;
    r_bo = borrow_out;
    chk("latency", r_lat, 4);
    chk("in_ready_done", in_ready, 1'b0);
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff_out_valid", out_valid, 1'b0);
    chk("handoff_in_ready", in_ready, 1'b1);
  endtask

  task automatic check_vs(input string name, input logic [W-1:0] ed, input logic en,
                          input logic ez, input logic ev, input logic eb);
    chk({name, "_diff"}, r_d, ed);
    chk({name, "_n"}, r_n, en);
    chk({name, "_z"}, r_z, ez);
    chk({name, "_v"}, r_v, ev);
    chk({name, "_borrow"}, r_bo, eb);
  endtask

  vec_t vecs[7];

  initial begin
    logic [W-1:0] md, hold_d;
    logic         mn, mz, mv, mb;

    vecs[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef NSUB_SATURATE_EN
    vecs[5] = '{16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    vecs[5] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_diff", diff, 16'h0000);
    chk("rst_flags", {flag_n, flag_z, flag_v}, 3'b000);
    chk("rst_borrow", borrow_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, 1'b0);
      check_vs($sformatf("vec%0d", i), vecs[i].diff, vecs[i].n, vecs[i].z,
               vecs[i].v, vecs[i].bo);
      handoff();
    end

    // DONE held with out_ready low while in_valid and operands toggle.
    do_op(16'h4321, 16'h0123, 1'b1);
    check_vs("hold", 16'h41FE, 1'b0, 1'b0, 1'b0, 1'b0);
    hold_d = diff;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("hold_diff", diff, hold_d);
      chk("hold_flags", {out_valid, in_ready, flag_n, flag_z, flag_v, borrow_out}, 6'b100000);
    end
    in_valid = 1'b0;
    handoff();

    // Reset while RUN is on step 2.
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'hABCD;
    b = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_diff", diff, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_no_result", out_valid, 1'b0);
    do_op(16'h00FF, 16'h0001, 1'b0);
    check_vs("post_rst", 16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0);
    handoff();

    // Randomized ops against the reference model, half with busy-time noise.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = ra;
      if (i % 8 == 1) ra = 16'h8000 | W'($urandom_range(0, 15));
      do_op(ra, rb, 1'(i % 2));
      model(ra, rb, md, mn, mz, mv, mb);
      check_vs($sformatf("rand%0d", i), md, mn, mz, mv, mb);
      handoff();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
